// File: rtl/tmds_period_sched.sv
// Video-period scheduler for the three TMDS encoders: raster timing, de/c0/c1 control, pixel requests.
// Define VIDEO_GUARD_BAND_EN to insert HDMI video preamble and guard-band periods before active video.
module tmds_period_sched #(
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   H_VALID  = 640,
    parameter int   H_FRONT  = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_VALID  = 480,
    parameter int   V_FRONT  = 10,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [3:0] ctl,
    output logic       vgb,
    output logic       pix_req,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_start
);
    localparam int H_TOTAL  = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HA_START = H_SYNC + H_BACK;
    localparam int VA_START = V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST_C    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST_C    = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SYNC_C    = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_C    = 12'(V_SYNC);
    localparam logic [11:0] HA_START_C  = 12'(HA_START);
    localparam logic [11:0] HA_END_C    = 12'(HA_START + H_VALID);
    localparam logic [11:0] REQ_START_C = 12'(HA_START - 1);
    localparam logic [11:0] REQ_END_C   = 12'(HA_START + H_VALID - 1);
    localparam logic [11:0] VA_START_C  = 12'(VA_START);
    localparam logic [11:0] VA_END_C    = 12'(VA_START + V_VALID);

`ifdef VIDEO_GUARD_BAND_EN
    localparam logic [11:0] PRE_START_C = 12'(HA_START - 10);
    localparam logic [11:0] GB_START_C  = 12'(HA_START - 2);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CTRL     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_GUARD    = 3'd3,
        ST_VIDEO    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CTRL  = 3'd1,
        ST_VIDEO = 3'd4
    } state_t;
`endif

    state_t      state_r;
    state_t      state_nxt_s;
    logic [11:0] h_cnt_r;
    logic [11:0] v_cnt_r;
    logic [11:0] h_nxt_s;
    logic [11:0] v_nxt_s;
    logic        frame_end_s;
    logic        run_s;
    logic        line_act_s;
    logic        req_nxt_s;

    logic       hsync_r;
    logic       vsync_r;
    logic       de_r;
    logic       pix_req_r;
    logic [9:0] pix_x_r;
    logic [9:0] pix_y_r;
    logic       frame_start_r;

    // Raster position for the next cycle; a stop request only lands once the frame's last pixel is out
    always_comb begin
        frame_end_s = (h_cnt_r == H_LAST_C) && (v_cnt_r == V_LAST_C);
        if (state_r == ST_IDLE) begin
            run_s = en;
        end else begin
            run_s = en || !frame_end_s;
        end
        if (!run_s || (state_r == ST_IDLE) || frame_end_s) begin
            h_nxt_s = 12'd0;
            v_nxt_s = 12'd0;
        end else if (h_cnt_r == H_LAST_C) begin
            h_nxt_s = 12'd0;
            v_nxt_s = v_cnt_r + 12'd1;
        end else begin
            h_nxt_s = h_cnt_r + 12'd1;
            v_nxt_s = v_cnt_r;
        end
    end

    // Period decode of the next raster position
    always_comb begin
        line_act_s = (v_nxt_s >= VA_START_C) && (v_nxt_s < VA_END_C);
        req_nxt_s  = run_s && line_act_s && (h_nxt_s >= REQ_START_C) && (h_nxt_s < REQ_END_C);
        if (!run_s) begin
            state_nxt_s = ST_IDLE;
        end else if (line_act_s && (h_nxt_s >= HA_START_C) && (h_nxt_s < HA_END_C)) begin
            state_nxt_s = ST_VIDEO;
`ifdef VIDEO_GUARD_BAND_EN
        end else if (line_act_s && (h_nxt_s >= PRE_START_C) && (h_nxt_s < GB_START_C)) begin
            state_nxt_s = ST_PREAMBLE;
        end else if (line_act_s && (h_nxt_s >= GB_START_C) && (h_nxt_s < HA_START_C)) begin
            state_nxt_s = ST_GUARD;
`endif
        end else begin
            state_nxt_s = ST_CTRL;
        end
    end

`ifdef VIDEO_GUARD_BAND_EN
    logic [3:0] ctl_r;
    logic       vgb_r;

    // Preamble and guard-band control symbols, registered alongside the other outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ctl_r <= 4'b0000;
            vgb_r <= 1'b0;
        end else begin
            ctl_r <= (state_nxt_s == ST_PREAMBLE) ? 4'b0001 : 4'b0000;
            vgb_r <= (state_nxt_s == ST_GUARD);
        end
    end

    assign ctl = ctl_r;
    assign vgb = vgb_r;
`else
    assign ctl = 4'b0000;
    assign vgb = 1'b0;
`endif

    // Period FSM, counters and all timing outputs advance together so every output matches one position
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r       <= ST_IDLE;
            h_cnt_r       <= 12'd0;
            v_cnt_r       <= 12'd0;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            de_r          <= 1'b0;
            pix_req_r     <= 1'b0;
            pix_x_r       <= 10'd0;
            pix_y_r       <= 10'd0;
            frame_start_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            h_cnt_r       <= h_nxt_s;
            v_cnt_r       <= v_nxt_s;
            hsync_r       <= (run_s && (h_nxt_s < H_SYNC_C)) ? SYNC_POL : ~SYNC_POL;
            vsync_r       <= (run_s && (v_nxt_s < V_SYNC_C)) ? SYNC_POL : ~SYNC_POL;
            de_r          <= (state_nxt_s == ST_VIDEO);
            pix_req_r     <= req_nxt_s;
            pix_x_r       <= req_nxt_s ? 10'(h_nxt_s - HA_START_C + 12'd1) : 10'd0;
            pix_y_r       <= (run_s && line_act_s) ? 10'(v_nxt_s - VA_START_C) : 10'd0;
            frame_start_r <= run_s && (h_nxt_s == 12'd0) && (v_nxt_s == 12'd0);
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign de          = de_r;
    assign pix_req     = pix_req_r;
    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_tmds_period_sched.sv
// Bench for tmds_period_sched: a linear-pixel-index raster model checked every cycle, plus
// directed literal checks for period lengths, request lead, deferred stop and asynchronous reset.
module tb_tmds_period_sched;
    localparam int HS = 4, HB = 12, HV = 8, HF = 4;
    localparam int VS = 1, VB = 2, VV = 3, VF = 1;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int HA = HS + HB;
    localparam int VA = VS + VB;
`ifdef VIDEO_GUARD_BAND_EN
    localparam bit GB = 1'b1;
`else
    localparam bit GB = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       en = 1'b0;
    logic       hsync, vsync, de, vgb, pix_req, frame_start;
    logic [3:0] ctl;
    logic [9:0] pix_x, pix_y;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;
    bit m_run = 1'b0;
    int m_lin = 0;

    tmds_period_sched #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .SYNC_POL(1'b1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
        .hsync(hsync), .vsync(vsync), .de(de), .ctl(ctl), .vgb(vgb),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: running flag plus linear pixel index within the frame
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_run <= 1'b0;
            m_lin <= 0;
        end else if (!m_run || m_lin == HT * VT - 1) begin
            m_run <= en;
            m_lin <= 0;
        end else begin
            m_lin <= m_lin + 1;
        end
    end

    function automatic logic [29:0] expect_vec(bit run, int lin);
        int h, v;
        bit act, req, hs, vs, dv, pre, gb, fs;
        logic [9:0] px, py;
        h   = lin % HT;
        v   = lin / HT;
        act = run && (v >= VA) && (v < VA + VV);
        hs  = run && (h < HS);
        vs  = run && (v < VS);
        dv  = act && (h >= HA) && (h < HA + HV);
        req = act && (h >= HA - 1) && (h < HA + HV - 1);
        pre = GB && act && (h >= HA - 10) && (h < HA - 2);
        gb  = GB && act && (h >= HA - 2) && (h < HA);
        fs  = run && (lin == 0);
        px  = req ? 10'(h + 1 - HA) : 10'd0;
        py  = act ? 10'(v - VA) : 10'd0;
        return {hs, vs, dv, 3'b000, pre, gb, req, px, py, fs};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {hsync, vsync, de, ctl, vgb, pix_req, pix_x, pix_y, frame_start};
    endfunction

    task automatic check(input string name, input int got, input int exp_v);
        total++;
        if (got != exp_v) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
        end
    endtask

    // Per-cycle comparison against the reference
    always @(negedge sys_clk) begin
        logic [29:0] got, exp_v;
        if (chk_on) begin
            got   = dut_vec();
            exp_v = expect_vec(m_run, m_lin);
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL model t=%0t got=%h exp=%h", $time, got, exp_v);
            end
        end
    end

    initial begin
        int fs_at, de_n, hs_n, ctl_n, vgb_n, req_rise, de_rise, idle_bad;
        int px[8];
        bit prev_req, prev_de, found;

        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        chk_on = 1'b1;
        @(negedge sys_clk);
        check("rst_vec", int'(dut_vec()), 0);

        #1 en = 1'b1;
        @(negedge sys_clk);
        check("start_fs", int'(frame_start), 1);
        check("start_hsync", int'(hsync), 1);
        fs_at = -1; req_rise = -1; de_rise = -1;
        de_n = 0; ctl_n = 0; vgb_n = 0;
        hs_n = int'(hsync);
        prev_req = 1'b0; prev_de = 1'b0;
        for (int i = 1; i <= HT * VT; i++) begin
            @(negedge sys_clk);
            if (frame_start && fs_at < 0) fs_at = i;
            if (i < HT * VT) begin
                de_n  += int'(de);
                hs_n  += int'(hsync);
                ctl_n += int'(ctl != 4'b0000);
                vgb_n += int'(vgb);
            end
            if (pix_req && !prev_req && req_rise < 0) req_rise = i;
            if (de && !prev_de && de_rise < 0) de_rise = i;
            if (req_rise >= 0 && i - req_rise < 8) px[i - req_rise] = int'(pix_x);
            prev_req = pix_req;
            prev_de  = de;
        end
        check("fs_period", fs_at, 196);
        check("de_per_frame", de_n, 24);
        check("hsync_per_frame", hs_n, 28);
        check("req_rise_idx", req_rise, 3 * 28 + 15);
        check("de_after_req", de_rise - req_rise, 1);
        for (int k = 0; k < 8; k++) check("pix_x_step", px[k], k);
        check("ctl_per_frame", ctl_n, GB ? 24 : 0);
        check("vgb_per_frame", vgb_n, GB ? 6 : 0);

        // Deferred stop: drop en at start of line 2, frame must finish through line 6
        repeat (2 * HT) @(negedge sys_clk);
        #1 en = 1'b0;
        hs_n = int'(hsync);
        de_n = int'(de);
        for (int j = 1; j < 5 * HT; j++) begin
            @(negedge sys_clk);
            hs_n += int'(hsync);
            de_n += int'(de);
        end
        check("stop_hsync_cnt", hs_n, 20);
        check("stop_de_cnt", de_n, 24);
        idle_bad = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge sys_clk);
            if (dut_vec() != 30'd0) idle_bad++;
        end
        check("idle_quiet", idle_bad, 0);
        #1 en = 1'b1;
        @(negedge sys_clk);
        check("restart_fs", int'(frame_start), 1);

        // Asynchronous reset while de is high
        found = 1'b0;
        for (int j = 0; j < 400 && !found; j++) begin
            @(negedge sys_clk);
            if (de) found = 1'b1;
        end
        check("wait_de", int'(found), 1);
        #2 sys_rst_n = 1'b0;
        #1 check("async_rst_vec", int'(dut_vec()), 0);
        en = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle_bad = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge sys_clk);
            if (dut_vec() != 30'd0) idle_bad++;
        end
        check("post_rst_idle", idle_bad, 0);
        #1 en = 1'b1;
        @(negedge sys_clk);
        check("post_rst_fs", int'(frame_start), 1);

        // Random en activity with occasional short resets, checked by the reference each cycle
        for (int i = 0; i < 6000; i++) begin
            @(negedge sys_clk);
            #1;
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 999) == 0) begin
                sys_rst_n = 1'b0;
                #2 sys_rst_n = 1'b1;
            end
        end
        @(negedge sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmds_period_sched.md
# tmds_period_sched

Video-period scheduler that sequences the three TMDS channel encoders of the HDMI transmitter. It generates raster timing and drives the encoders' control inputs: per-channel c0/c1 and the shared de. It also issues a pixel request one cycle ahead of active video and, optionally, inserts HDMI video preamble and guard-band periods. It sits between the pixel source (colorbar/pattern generator) and the three encoder instances.

## Interface
Parameters:
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, back porch (pixels); must be ≥ 10 when VIDEO_GUARD_BAND_EN is defined
- H_VALID, 640, active pixels per line
- H_FRONT, 16, front porch (pixels); H_TOTAL = sum of the four H parameters
- V_SYNC, 2; V_BACK, 33; V_VALID, 480; V_FRONT, 10; lines; V_TOTAL = sum of the four V parameters
- SYNC_POL, 1, active level of hsync/vsync

Ports:
- sys_clk  in  1  pixel clock
- sys_rst_n  in  1  reset; asynchronous, active-low
- en  in  1  run request
- hsync  out  1  to ch0 c0
- vsync  out  1  to ch0 c1
- de  out  1  to all three encoders
- ctl  out  4  {ch2 c1, ch2 c0, ch1 c1, ch1 c0} = {CTL3, CTL2, CTL1, CTL0}
- vgb  out  1  video guard band active (selects guard-band symbol downstream)
- pix_req  out  1  pixel fetch request, one cycle before de
- pix_x  out  10  active-pixel column for the pixel being requested
- pix_y  out  10  active-line row
- frame_start  out  1  one-cycle pulse at h_cnt = 0, v_cnt = 0

## Operation
- h_cnt runs 0 to H_TOTAL-1 and wraps. v_cnt increments on each h wrap, 0 to V_TOTAL-1, and wraps.
- HA_START = H_SYNC + H_BACK. VA_START = V_SYNC + V_BACK.
- Active line: VA_START ≤ v_cnt < VA_START + V_VALID.
- hsync = SYNC_POL when h_cnt < H_SYNC. vsync = SYNC_POL when v_cnt < V_SYNC.
- de = 1 when the line is active and HA_START ≤ h_cnt < HA_START + H_VALID.
- pix_req = 1 on active lines when HA_START-1 ≤ h_cnt < HA_START+H_VALID-1.
- pix_x = h_cnt + 1 - HA_START while pix_req = 1, else 0. pix_y = v_cnt - VA_START on active lines, else 0.
- Period FSM states: IDLE, CTRL, PREAMBLE, GUARD, VIDEO.
  - IDLE → CTRL when en = 1; counters start from (0,0) with frame_start.
  - CTRL → PREAMBLE at h_cnt = HA_START-10 on an active line.
  - PREAMBLE (8 cycles) → GUARD (2 cycles) → VIDEO (H_VALID cycles) → CTRL.
  - Without the macro: CTRL → VIDEO directly at HA_START.
- Outputs per state:
  - PREAMBLE: ctl = 4'b0001.
  - GUARD: vgb = 1, ctl = 0.
  - VIDEO: de = 1.
  - All other states: ctl = 0, vgb = 0, de = 0.
- en is sampled every cycle.
  - Rise in IDLE starts output on the next cycle.
  - Fall takes effect only at the end of the frame: the last cycle of v_cnt = V_TOTAL-1 finishes, then the FSM enters IDLE. A frame in progress is never truncated.
  - en re-asserted before the frame end cancels the stop.
- IDLE outputs: sync inactive, de = 0, ctl = 0, vgb = 0, pix_req = 0, counters held at 0.

## Timing
- All outputs are registered and mutually aligned: the values in a cycle correspond to the same (h_cnt, v_cnt).
- The encoder delays de, c0 and c1 by an equal 2 cycles, so data presented with de stays aligned.
- A source that registers pixel data on pix_req delivers it coincident with de.
- Reset values: hsync = vsync = ~SYNC_POL; de, ctl, vgb, pix_req, pix_x, pix_y, frame_start = 0; FSM = IDLE.
- Reset mid-frame: immediate return to reset values. Restart requires en = 1 after release.
- Line wrap and frame wrap occur on the same cycle at h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1. frame_start asserts on the following cycle.

## Configuration
- VIDEO_GUARD_BAND_EN defined: PREAMBLE and GUARD states are present. ctl and vgb are driven as described in Operation.
- VIDEO_GUARD_BAND_EN undefined: both states are removed, ctl ties to 0 and vgb ties to 0 (DVI-compatible output). hsync, vsync, de and pix_req timing are unchanged.

## Test plan
- Parameters H 4/12/8/4, V 1/2/3/1; en = 1 after reset:
  - frame_start pulses every 28 × 7 = 196 cycles.
  - de is high 8 cycles per line on lines 3–5 only.
  - hsync is high for h_cnt 0–3.
- Same parameters:
  - pix_req is high at h_cnt 15–22.
  - pix_x steps 0..7.
  - The de rising edge is exactly 1 cycle after the pix_req rising edge.
- Macro defined, same parameters:
  - ctl = 0001 at h_cnt 6–13 of active lines.
  - vgb = 1 at h_cnt 14–15.
  - ctl = 0 and vgb = 0 on blank lines.
- en dropped mid-frame at v_cnt = 2:
  - Output continues to the end of v_cnt = 6, then IDLE with de = 0 and hsync = 0.
  - Re-asserting en produces frame_start on the next cycle.
- sys_rst_n asserted during de = 1: all outputs reach reset values asynchronously, the same cycle, and remain there until en restarts.
